pipe_ctl_unit: RTL and testbench

Pipeline control unit for the 5-stage MIPS core. It replaces the tied-high `i_pc_we` / `i_if_id_we` of the fetch stage with real run control:
- detects load-use and branch-in-decode data hazards and inserts stalls/bubbles;
- sequences start, single-step, halt and drain;
- keeps saturating cycle and stall counters for the debug path.

It sits beside the forwarding unit and drives the write enables of the PC, IF/ID and ID/EX latches.

---
 rtl/pipe_ctl_unit.sv | 153 +++++++++++++++
 tb/tb_pipe_ctl_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctl_unit.sv
// Pipeline run control for the 5-stage MIPS core: hazard stalls, start/step/halt/drain, perf counters.
// Optional single-step support is compiled in with the PIPE_CTL_STEP_EN macro.
module pipe_ctl_unit #(
  parameter int NB_REG       = 5,
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter int BRANCH_IN_ID = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_halt,
  input  logic [NB_REG-1:0] i_if_id_rs,
  input  logic [NB_REG-1:0] i_if_id_rt,
  input  logic              i_if_id_uses_rt,
  input  logic              i_if_id_branch,
  input  logic [NB_REG-1:0] i_id_ex_dst,
  input  logic              i_id_ex_mem_read,
  input  logic              i_id_ex_reg_we,
  input  logic [NB_REG-1:0] i_ex_mem_dst,
  input  logic              i_ex_mem_mem_read,
  output logic              o_pc_we,
  output logic              o_if_id_we,
  output logic              o_if_id_flush,
  output logic              o_id_ex_bubble,
  output logic              o_pipe_en,
  output logic [2:0]        o_state,
  output logic              o_done,
  output logic [NB_CNT-1:0] o_cycle_cnt,
  output logic [NB_CNT-1:0] o_stall_cnt
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_STEP  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int                NB_DRN   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRN-1:0] DRN_LOAD = NB_DRN'(DRAIN_CYCLES - 1);
  localparam logic [NB_DRN-1:0] DRN_ONE  = {{(NB_DRN-1){1'b0}}, 1'b1};
  localparam logic [NB_CNT-1:0] CNT_MAX  = {NB_CNT{1'b1}};
  localparam logic [NB_CNT-1:0] CNT_ONE  = {{(NB_CNT-1){1'b0}}, 1'b1};

  // Register 0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [NB_REG-1:0] a, input logic [NB_REG-1:0] b);
    return (a == b) && (a != {NB_REG{1'b0}});
  endfunction

  logic [2:0]        state, state_nxt;
  logic [NB_DRN-1:0] drn_cnt, drn_cnt_nxt;
  logic              active, lu, br1, br2, stall;

`ifndef PIPE_CTL_STEP_EN
  logic unused_step;
  assign unused_step = i_step;
`endif

  // Hazard detection against the instructions in EX and MEM.
  always_comb begin
    lu = i_id_ex_mem_read &&
         (reg_match(i_id_ex_dst, i_if_id_rs) ||
          (i_if_id_uses_rt && reg_match(i_id_ex_dst, i_if_id_rt)));
    if (BRANCH_IN_ID != 0) begin
      br1 = i_if_id_branch && i_id_ex_reg_we &&
            (reg_match(i_id_ex_dst, i_if_id_rs) || reg_match(i_id_ex_dst, i_if_id_rt));
      br2 = i_if_id_branch && i_ex_mem_mem_read &&
            (reg_match(i_ex_mem_dst, i_if_id_rs) || reg_match(i_ex_mem_dst, i_if_id_rt));
    end else begin
      br1 = 1'b0;
      br2 = 1'b0;
    end
    active = (state == ST_RUN) || (state == ST_STEP);
    stall  = active && (lu || br1 || br2);
  end

  // Latch enables decoded from state and the current hazard.
  always_comb begin
    o_pc_we        = 1'b0;
    o_if_id_we     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_en      = 1'b0;
    o_done         = 1'b0;
    case (state)
      ST_RUN, ST_STEP: begin
        o_pipe_en      = 1'b1;
        o_pc_we        = !stall;
        o_if_id_we     = !stall;
        o_id_ex_bubble = stall;
      end
      ST_DRAIN: begin
        o_pipe_en     = 1'b1;
        o_if_id_we    = 1'b1;
        o_if_id_flush = 1'b1;
      end
      ST_DONE:  o_done = 1'b1;
      default:  o_done = 1'b0;
    endcase
  end

  // Run-control sequencing; a halt seen during a stall waits for the stall to clear.
  always_comb begin
    state_nxt   = state;
    drn_cnt_nxt = drn_cnt;
    case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = ST_RUN;
`ifdef PIPE_CTL_STEP_EN
        else if (i_step) state_nxt = ST_STEP;
`endif
        else state_nxt = ST_IDLE;
      end
      ST_RUN, ST_STEP: begin
        if (i_halt && !stall) begin
          state_nxt   = ST_DRAIN;
          drn_cnt_nxt = DRN_LOAD;
        end else if (state == ST_STEP) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drn_cnt == {NB_DRN{1'b0}}) state_nxt = ST_DONE;
        else drn_cnt_nxt = drn_cnt - DRN_ONE;
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, drain countdown and saturating performance counters.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= ST_IDLE;
      drn_cnt     <= {NB_DRN{1'b0}};
      o_cycle_cnt <= {NB_CNT{1'b0}};
      o_stall_cnt <= {NB_CNT{1'b0}};
    end else begin
      state   <= state_nxt;
      drn_cnt <= drn_cnt_nxt;
      if (o_pipe_en && (o_cycle_cnt != CNT_MAX)) o_cycle_cnt <= o_cycle_cnt + CNT_ONE;
      else o_cycle_cnt <= o_cycle_cnt;
      if (stall && (o_stall_cnt != CNT_MAX)) o_stall_cnt <= o_stall_cnt + CNT_ONE;
      else o_stall_cnt <= o_stall_cnt;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pipe_ctl_unit.sv
// Randomized bench for pipe_ctl_unit: three configurations share one stimulus stream and are
// compared every cycle against a behavioural model of the run-control rules.
module tb_pipe_ctl_unit;
  localparam int NI = 3;

`ifdef PIPE_CTL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, step, halt, uses_rt, branch, mr, rwe, mmr;
  logic [4:0] rs, rt, exd, memd;

  logic        pc_we [NI], if_id_we [NI], flush [NI], bubble [NI], pipe_en [NI], done [NI];
  logic [2:0]  st [NI];
  logic [31:0] cyc [NI], stl [NI];
  logic [3:0]  cyc4, stl4;
  assign cyc[2] = {28'd0, cyc4};
  assign stl[2] = {28'd0, stl4};

  pipe_ctl_unit #(.NB_REG(5), .NB_CNT(32), .DRAIN_CYCLES(4), .BRANCH_IN_ID(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_step(step), .i_halt(halt),
    .i_if_id_rs(rs), .i_if_id_rt(rt), .i_if_id_uses_rt(uses_rt), .i_if_id_branch(branch),
    .i_id_ex_dst(exd), .i_id_ex_mem_read(mr), .i_id_ex_reg_we(rwe),
    .i_ex_mem_dst(memd), .i_ex_mem_mem_read(mmr),
    .o_pc_we(pc_we[0]), .o_if_id_we(if_id_we[0]), .o_if_id_flush(flush[0]),
    .o_id_ex_bubble(bubble[0]), .o_pipe_en(pipe_en[0]), .o_state(st[0]), .o_done(done[0]),
    .o_cycle_cnt(cyc[0]), .o_stall_cnt(stl[0]));

  pipe_ctl_unit #(.NB_REG(5), .NB_CNT(32), .DRAIN_CYCLES(4), .BRANCH_IN_ID(0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_step(step), .i_halt(halt),
    .i_if_id_rs(rs), .i_if_id_rt(rt), .i_if_id_uses_rt(uses_rt), .i_if_id_branch(branch),
    .i_id_ex_dst(exd), .i_id_ex_mem_read(mr), .i_id_ex_reg_we(rwe),
    .i_ex_mem_dst(memd), .i_ex_mem_mem_read(mmr),
    .o_pc_we(pc_we[1]), .o_if_id_we(if_id_we[1]), .o_if_id_flush(flush[1]),
    .o_id_ex_bubble(bubble[1]), .o_pipe_en(pipe_en[1]), .o_state(st[1]), .o_done(done[1]),
    .o_cycle_cnt(cyc[1]), .o_stall_cnt(stl[1]));

  pipe_ctl_unit #(.NB_REG(5), .NB_CNT(4), .DRAIN_CYCLES(2), .BRANCH_IN_ID(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_step(step), .i_halt(halt),
    .i_if_id_rs(rs), .i_if_id_rt(rt), .i_if_id_uses_rt(uses_rt), .i_if_id_branch(branch),
    .i_id_ex_dst(exd), .i_id_ex_mem_read(mr), .i_id_ex_reg_we(rwe),
    .i_ex_mem_dst(memd), .i_ex_mem_mem_read(mmr),
    .o_pc_we(pc_we[2]), .o_if_id_we(if_id_we[2]), .o_if_id_flush(flush[2]),
    .o_id_ex_bubble(bubble[2]), .o_pipe_en(pipe_en[2]), .o_state(st[2]), .o_done(done[2]),
    .o_cycle_cnt(cyc4), .o_stall_cnt(stl4));

  // Reference model: per-instance configuration and abstract state.
  int     br_cfg  [NI] = '{1, 0, 1};
  int     dc_cfg  [NI] = '{4, 4, 2};
  longint max_cfg [NI] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  typedef enum int {M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_DONE = 4} mst_t;
  mst_t   m_st   [NI];
  int     m_left [NI];
  longint m_cyc  [NI], m_stl [NI];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  function automatic bit m_stall(input int k);
    bit running, hz;
    running = (m_st[k] == M_RUN) || (m_st[k] == M_STEP);
    hz = mr && (dep(exd, rs) || (uses_rt && dep(exd, rt)));
    if (br_cfg[k] != 0) begin
      hz = hz || (branch && rwe && (dep(exd, rs) || dep(exd, rt)));
      hz = hz || (branch && mmr && (dep(memd, rs) || dep(memd, rt)));
    end
    return running && hz;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_st[k] = M_IDLE; m_left[k] = 0; m_cyc[k] = 0; m_stl[k] = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      bit s, running;
      s = m_stall(k);
      running = (m_st[k] == M_RUN) || (m_st[k] == M_STEP);
      check($sformatf("d%0d.state", k), st[k], m_st[k]);
      check($sformatf("d%0d.pc_we", k), pc_we[k], running && !s);
      check($sformatf("d%0d.if_id_we", k), if_id_we[k], (running && !s) || (m_st[k] == M_DRAIN));
      check($sformatf("d%0d.flush", k), flush[k], m_st[k] == M_DRAIN);
      check($sformatf("d%0d.bubble", k), bubble[k], s);
      check($sformatf("d%0d.pipe_en", k), pipe_en[k], running || (m_st[k] == M_DRAIN));
      check($sformatf("d%0d.done", k), done[k], m_st[k] == M_DONE);
      check($sformatf("d%0d.cycle_cnt", k), cyc[k], m_cyc[k]);
      check($sformatf("d%0d.stall_cnt", k), stl[k], m_stl[k]);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      bit s, en;
      s  = m_stall(k);
      en = (m_st[k] == M_RUN) || (m_st[k] == M_STEP) || (m_st[k] == M_DRAIN);
      if (en && m_cyc[k] < max_cfg[k]) m_cyc[k]++;
      if (s && m_stl[k] < max_cfg[k]) m_stl[k]++;
      case (m_st[k])
        M_IDLE:  if (start) m_st[k] = M_RUN; else if (step && STEP_EN) m_st[k] = M_STEP;
        M_RUN, M_STEP: begin
          if (halt && !s) begin m_st[k] = M_DRAIN; m_left[k] = dc_cfg[k]; end
          else if (m_st[k] == M_STEP) m_st[k] = M_IDLE;
        end
        M_DRAIN: begin m_left[k]--; if (m_left[k] == 0) m_st[k] = M_DONE; end
        default: m_st[k] = m_st[k];
      endcase
    end
  endtask

  task automatic idle_inputs();
    start = 0; step = 0; halt = 0; uses_rt = 0; branch = 0; mr = 0; rwe = 0; mmr = 0;
    rs = 0; rt = 0; exd = 0; memd = 0;
  endtask

  task automatic rand_inputs(input int halt_pct, input int start_pct, input int step_pct);
    rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
    exd = 5'($urandom_range(0, 3)); memd = 5'($urandom_range(0, 3));
    uses_rt = 1'($urandom % 2); branch = 1'($urandom % 2);
    mr = 1'($urandom % 2); rwe = 1'($urandom % 2); mmr = 1'($urandom % 2);
    halt  = ($urandom_range(0, 99) < 32'(halt_pct));
    start = ($urandom_range(0, 99) < 32'(start_pct));
    step  = ($urandom_range(0, 99) < 32'(step_pct));
  endtask

  // Called at a falling edge with inputs already driven; ends at the next falling edge.
  task automatic cycle();
    #1;
    check_all();
    model_step();
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #3 rst = 0;
    #1;
    model_reset();
    idle_inputs();
    #1;
    check("rst.state", st[0], 0);
    check("rst.cycle_cnt", cyc[0], 0);
    check("rst.pipe_en", pipe_en[0], 0);
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    int nb0, nb1, ndrain;
    longint s0;
    rst = 1; idle_inputs(); model_reset();
    @(negedge clk);
    do_reset();

    // Long hazard-free run, then reset with the counters well past 100.
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 105; i++) begin
      rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31)); exd = rs;
      cycle();
    end
    check("run.cycle_cnt", cyc[0], 105);
    check("sat4.cycle_cnt", cyc[2], 15);
    do_reset();

    // Load-use, then the same with destination register 0.
    start = 1; cycle(); start = 0;
    s0 = stl[0];
    mr = 1; exd = 5'd5; rs = 5'd5;
    #1;
    check("lu.pc_we", pc_we[0], 0);
    check("lu.if_id_we", if_id_we[0], 0);
    check("lu.bubble", bubble[0], 1);
    cycle();
    check("lu.stall_cnt", stl[0], s0 + 1);
    exd = 5'd0; rs = 5'd0;
    #1;
    check("lu0.pc_we", pc_we[0], 1);
    cycle();
    idle_inputs();

    // Branch on an ALU result whose producer is followed by a load into MEM.
    nb0 = 0; nb1 = 0;
    branch = 1; rs = 5'd3; rwe = 1; exd = 5'd3;
    #1; nb0 += int'(bubble[0]); nb1 += int'(bubble[1]);
    cycle();
    rwe = 0; exd = 5'd0; mmr = 1; memd = 5'd3;
    #1; nb0 += int'(bubble[0]); nb1 += int'(bubble[1]);
    cycle();
    check("br.stalls_on", nb0, 2);
    check("br.stalls_off", nb1, 0);
    idle_inputs();

    // Halt, drain, then absorbing DONE with start ignored.
    halt = 1; cycle(); halt = 0; start = 1;
    ndrain = 0;
    for (int i = 0; i < 12; i++) begin
      #1; if (st[0] == 3'd3) ndrain++;
      cycle();
    end
    check("drain.len", ndrain, 4);
    check("done.state", st[0], 4);
    check("done.flag", done[0], 1);
    do_reset();

    // Single-step pulses from IDLE.
    for (int p = 0; p < 3; p++) begin
      step = 1; cycle(); step = 0; cycle();
      #1; check("step.state", st[0], 0);
    end
    check("step.cycle_cnt", cyc[0], STEP_EN ? 3 : 0);

    // Randomized operation with occasional resets.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 120; i++) begin
        rand_inputs(3, 20, 15);
        cycle();
      end
      do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
